// File: rtl/fp_operand_responder.sv
// Strobe/ack operand responder wrapping a start/done compute core.
// Define FP_RESP_TIMEOUT_EN to bound the WAIT state and force a qNaN result on expiry.
module fp_operand_responder #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic             strb_A,
    output logic             in_A_ack,
    input  logic [WIDTH-1:0] in_B,
    input  logic             strb_B,
    output logic             in_B_ack,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             core_start,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic [WIDTH-1:0] out_z,
    output logic             out_z_stb,
    input  logic             out_z_ack,
    output logic             busy,
    output logic [7:0]       cycle_count,
    output logic             timeout_err
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] START   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] OUTPUT  = 2'd3;

    // Counter must be able to reach both 255 and TIMEOUT_CYCLES before saturating.
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             a_full;
    logic             b_full;
    logic             cap_a;
    logic             cap_b;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic [7:0]       lat_sat;
    logic             wait_exit;

    assign cap_a = (state == COLLECT) && strb_A && !a_full;
    assign cap_b = (state == COLLECT) && strb_B && !b_full;

    assign wait_inc = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);
    assign lat_sat  = (wait_inc > CNT_W'(255)) ? 8'd255 : wait_inc[7:0];

`ifdef FP_RESP_TIMEOUT_EN
    localparam logic [WIDTH-1:0] QNAN  = WIDTH'(32'h7FC0_0000);
    localparam logic [7:0]       TO_CC = (TIMEOUT_CYCLES > 255) ? 8'd255 : 8'(TIMEOUT_CYCLES);

    logic timeout_hit;
    logic timeout_q;

    assign timeout_hit = !core_done && (32'(wait_inc) >= TIMEOUT_CYCLES);
    assign wait_exit   = core_done || timeout_hit;
    assign timeout_err = timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (state == WAIT) begin
            if (core_done) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wait_exit   = core_done;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if ((a_full || cap_a) && (b_full || cap_b)) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (wait_exit) state_next = OUTPUT;
            OUTPUT:  if (out_z_ack) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            a_full      <= 1'b0;
            b_full      <= 1'b0;
            in_A_ack    <= 1'b0;
            in_B_ack    <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            wait_cnt    <= '0;
            out_z       <= '0;
            cycle_count <= '0;
        end else begin
            state    <= state_next;
            in_A_ack <= cap_a;
            in_B_ack <= cap_b;
            if (cap_a) begin
                a_full <= 1'b1;
                core_a <= in_A;
            end
            if (cap_b) begin
                b_full <= 1'b1;
                core_b <= in_B;
            end
            // Slots only drain once the result has been handed over.
            if (state == OUTPUT && out_z_ack) begin
                a_full <= 1'b0;
                b_full <= 1'b0;
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_inc;
            end
            if (state == WAIT) begin
                if (core_done) begin
                    out_z       <= core_result;
                    cycle_count <= lat_sat;
                end
`ifdef FP_RESP_TIMEOUT_EN
                else if (timeout_hit) begin
                    out_z       <= QNAN;
                    cycle_count <= TO_CC;
                end
`endif
            end
        end
    end

    assign core_start = (state == START);
    assign out_z_stb  = (state == OUTPUT);
    assign busy       = (state != COLLECT);

endmodule
